mem_access_master: RTL and testbench
====================================

Name: mem_access_master

Overview:
- Bus initiator between the MIPS core's load/store stage and a word-wide, byte-enabled memory responder.
- Accepts one CPU access at a time: byte, halfword or word, load or store.
- Drives word address, read/write strobes, byte enables and lane-placed write data.
- Waits out responder stall and fixed read latency, then returns extracted, sign- or zero-extended load data.

Parameters:
- ADDR_W, 32, width of the CPU and bus byte address.
- READ_LATENCY, 1, cycles from accepted read (read=1, waitrequest=0) to valid readdata; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  misaligned-access flag, qualified by resp_valid.
- address  out  ADDR_W  word-aligned byte address (bits [1:0] = 0).
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- byteenable  out  4  lane enables; bit k = byte offset k.
- writedata  out  32  lane k = bits [8k+7:8k].
- waitrequest  in  1  responder stall.
- readdata  in  32  bus read data, same lane mapping.

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - read, write, resp_valid and resp_err are 0.
  - byteenable, writedata, address and resp_rdata are 0.
  - req_ready = 1 after reset releases.
  - An in-flight access is abandoned; no response is produced for it.
- FSM states: IDLE, BUS, LAT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture request and go to BUS.
  - Bus outputs are registered, so the strobe appears the cycle after acceptance.
- BUS:
  - Hold read or write, address, byteenable and writedata stable while waitrequest = 1.
  - When waitrequest = 0 and the access is a write, drop the strobe and go to RESP.
  - When waitrequest = 0 and the access is a read, drop the strobe, load the latency counter with READ_LATENCY, and go to LAT.
- LAT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, sample readdata and go to RESP.
  - With READ_LATENCY = 1, sampling occurs on the cycle immediately after acceptance.
- RESP:
  - resp_valid = 1 for exactly one cycle, then go to IDLE.
  - req_ready = 0 in BUS, LAT and RESP.
- Minimum latency, request accept to resp_valid:
  - Write with no stall: 2 cycles.
  - Read with no stall: 2 + READ_LATENCY cycles.
- Lane placement, with off = req_addr[1:0]:
  - Byte: byteenable = 1 << off; writedata = {4{req_wdata[7:0]}}.
  - Half: byteenable = 0011 for off = 0, 1100 for off = 2; writedata = {2{req_wdata[15:0]}}.
  - Word: byteenable = 1111; writedata = req_wdata.
- Load extraction:
  - Byte: select lane off, extend from bit 7.
  - Half: select lanes off/off+1, extend from bit 15.
  - Word: pass through.
- Read accesses also drive byteenable per size and offset, for responders that honour it.
- req_valid while req_ready = 0 is ignored; the CPU must hold it.
- A request is accepted in the same IDLE cycle that follows RESP's return to IDLE; no back-to-back bypass.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request (half with off[0] = 1, or word with off != 0) issues no bus strobe.
  - The block goes IDLE -> RESP and returns resp_valid = 1, resp_err = 1, resp_rdata = 0.
- Undefined:
  - Offending low address bits are cleared (half uses off & 2'b10, word uses 00).
  - The access proceeds normally; resp_err is tied 0.

Test Plan:
- Store byte, addr 0x00000006, wdata 0x000000AB -> address 0x4, write = 1, byteenable 0100, writedata 0xABABABAB, resp_valid 2 cycles after accept.
- Load half signed, addr 0x0000000A, readdata 0x80F01234 -> byteenable 1100, resp_rdata 0xFFFF80F0; with req_unsigned = 1 -> 0x000080F0.
- Load word, addr 0x10, waitrequest held high 3 cycles -> read and address stable for all 4 strobe cycles; resp_rdata = readdata; resp_valid at cycle 5 + READ_LATENCY.
- READ_LATENCY = 3, load byte unsigned, addr 0x3, readdata 0x9A000000 -> resp_rdata 0x0000009A, sampled 3 cycles after read acceptance.
- Reset pulled low during LAT -> read = 0, resp_valid never asserts; after release req_ready = 1 and a new store completes normally.
- MISALIGN_TRAP_EN defined, load word, addr 0x2 -> no read strobe, resp_valid = 1, resp_err = 1 one cycle after accept; undefined -> word read at 0x0, resp_err = 0.

Source files
------------

// File: rtl/mem_access_master.sv
// Load/store bus initiator: one byte/half/word access at a time, lane placement and load extension.
// Latency accept->resp_valid: 2 (write) / 2+READ_LATENCY (read) plus stall; waitrequest holds the strobe, req_ready low while busy.
// Optional MISALIGN_TRAP_EN: misaligned requests skip the bus and return resp_err instead of being aligned down.
module mem_access_master #(
    parameter int ADDR_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    input  logic              waitrequest,
    input  logic [31:0]       readdata
);

    typedef enum logic [1:0] {IDLE, BUS, LAT, RESP} state_t;

    state_t            state_q, state_d;
    logic              read_q, read_d, write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d, off_q, off_d;
    logic              uns_q, uns_d, err_q, err_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              is_half, is_word, trap;
    logic [1:0]        off_eff;
    logic [3:0]        be_new;
    logic [31:0]       wd_new, rd_shift, rd_ext;

    assign is_word = req_size[1];
    assign is_half = (req_size == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Misaligned low bits are cleared; in trap mode those requests never reach the bus anyway.
    assign off_eff = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);

    always_comb begin
        be_new = 4'b1111;
        wd_new = req_wdata;
        if (!is_word && !is_half) begin
            be_new = 4'b0001 << off_eff;
            wd_new = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            be_new = off_eff[1] ? 4'b1100 : 4'b0011;
            wd_new = {2{req_wdata[15:0]}};
        end
    end

    assign rd_shift = readdata >> {off_q, 3'b000};

    always_comb begin
        rd_ext = rd_shift;
        case (size_q)
            2'b00:   rd_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    off_d   = off_eff;
                    uns_d   = req_unsigned;
                    err_d   = trap;
                    rdata_d = 32'h0;
                    if (trap) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUS;
                        read_d  = ~req_write;
                        write_d = req_write;
                        addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wd_new;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) begin
                        cnt_d   = 3'(READ_LATENCY);
                        state_d = LAT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            LAT: begin
                // Counter reaching zero this cycle is the cycle readdata is valid.
                if (cnt_q == 3'd1) begin
                    rdata_d = rd_ext;
                    cnt_d   = 3'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0;
            wdata_q <= 32'h0;
            size_q  <= 2'b0;
            off_q   <= 2'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_valid & err_q;
    assign address    = addr_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = be_q;
    assign writedata  = wdata_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master (READ_LATENCY = 3); bench-side responder drives readdata only in its valid cycle.
module tb_mem_access_master;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;

    int n_cmp = 0;
    int n_fail = 0;

    mem_access_master #(.ADDR_W(32), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    // Called at a negedge in IDLE; returns at the negedge after the response pulse.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                              input int stall, output int resp_cyc, output logic [31:0] rdat,
                              output logic err, output int nstrb, output logic [31:0] s_addr,
                              output logic [3:0] s_be, output logic [31:0] s_wd,
                              output logic s_rd, output logic s_wr, output logic stable);
        int acc;
        int left;
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; waitrequest = 1'b0; readdata = 32'hDEADBEEF;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_at_request: got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_cyc = -1; nstrb = 0; acc = -1; left = stall; stable = 1'b1;
        s_addr = 0; s_be = 0; s_wd = 0; s_rd = 0; s_wr = 0; rdat = 0; err = 0;
        for (int k = 1; k <= 40 && resp_cyc < 0; k++) begin
            @(negedge clk);
            if (read || write) begin
                if (nstrb == 0) begin
                    s_addr = address; s_be = byteenable; s_wd = writedata; s_rd = read; s_wr = write;
                end else if (address !== s_addr || byteenable !== s_be || writedata !== s_wd ||
                             read !== s_rd || write !== s_wr) begin
                    stable = 1'b0;
                end
                nstrb++;
                if (left > 0) begin
                    waitrequest = 1'b1; left--;
                end else begin
                    waitrequest = 1'b0; acc = k;
                end
            end else begin
                waitrequest = 1'b0;
            end
            readdata = (acc > 0 && k == acc + RL) ? rword : 32'hDEADBEEF;
            if (resp_valid === 1'b1) begin
                resp_cyc = k; rdat = resp_rdata; err = resp_err;
            end
        end
        n_cmp++;
        if (resp_cyc < 0) begin
            n_fail++; $display("FAIL resp_timeout: got no resp_valid expected one within 40 cycles");
        end
        @(negedge clk);
        readdata = 32'hDEADBEEF;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL resp_pulse: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({read, write, resp_valid, resp_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {read, write, resp_valid, resp_err});
        end
        n_cmp++;
        if ({address, writedata, resp_rdata, byteenable} !== 100'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h wd=%h rd=%h be=%b expected all 0", address, writedata, resp_rdata, byteenable);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_store_byte();
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        run_access(1'b1, 2'b00, 1'b0, 32'h6, 32'h000000AB, 32'h0, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if ({sr, swr, ns} !== {1'b0, 1'b1, 32'd1} || sa !== 32'h4 || sb !== 4'b0100 || sw !== 32'hABABABAB) begin
            n_fail++; $display("FAIL store_byte_bus: got wr=%b n=%0d addr=%h be=%b wd=%h expected wr=1 n=1 addr=4 be=0100 wd=abababab", swr, ns, sa, sb, sw);
        end
        n_cmp++;
        if (rc !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            n_fail++; $display("FAIL store_byte_resp: got cyc=%0d rd=%h err=%b expected cyc=2 rd=0 err=0", rc, rd, er);
        end
    endtask

    task automatic test_load_half();
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        run_access(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h80F01234, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (sr !== 1'b1 || sa !== 32'h8 || sb !== 4'b1100) begin
            n_fail++; $display("FAIL load_half_bus: got rd=%b addr=%h be=%b expected rd=1 addr=8 be=1100", sr, sa, sb);
        end
        n_cmp++;
        if (rc !== 2 + RL || rd !== 32'hFFFF80F0) begin
            n_fail++; $display("FAIL load_half_signed: got cyc=%0d rd=%h expected cyc=%0d rd=ffff80f0", rc, rd, 2 + RL);
        end
        run_access(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'h80F01234, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (rd !== 32'h000080F0) begin
            n_fail++; $display("FAIL load_half_unsigned: got %h expected 000080f0", rd);
        end
    endtask

    task automatic test_wait_stall();
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h13579BDF, 3, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (ns !== 4 || st !== 1'b1 || sa !== 32'h10 || sb !== 4'b1111) begin
            n_fail++; $display("FAIL stall_strobe: got n=%0d stable=%b addr=%h be=%b expected n=4 stable=1 addr=10 be=1111", ns, st, sa, sb);
        end
        n_cmp++;
        if (rc !== 5 + RL || rd !== 32'h13579BDF) begin
            n_fail++; $display("FAIL stall_resp: got cyc=%0d rd=%h expected cyc=%0d rd=13579bdf", rc, rd, 5 + RL);
        end
    endtask

    task automatic test_load_byte_lat();
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        run_access(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'h9A000000, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (rc !== 2 + RL || rd !== 32'h0000009A || sb !== 4'b1000 || sa !== 32'h0) begin
            n_fail++; $display("FAIL load_byte_u: got cyc=%0d rd=%h be=%b addr=%h expected cyc=%0d rd=9a be=1000 addr=0", rc, rd, sb, sa, 2 + RL);
        end
        run_access(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'h00008000, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (rd !== 32'hFFFFFF80 || sb !== 4'b0010 || sa !== 32'h4) begin
            n_fail++; $display("FAIL load_byte_s: got rd=%h be=%b addr=%h expected rd=ffffff80 be=0010 addr=4", rd, sb, sa);
        end
        run_access(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (rd !== 32'hCAFEF00D || sb !== 4'b1111) begin
            n_fail++; $display("FAIL load_size11: got rd=%h be=%b expected rd=cafef00d be=1111", rd, sb);
        end
    endtask

    task automatic test_back_to_back();
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        run_access(1'b1, 2'b01, 1'b0, 32'h2, 32'h1234CAFE, 32'h0, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (sb !== 4'b1100 || sw !== 32'hCAFECAFE || sa !== 32'h0 || rc !== 2) begin
            n_fail++; $display("FAIL b2b_store_half: got be=%b wd=%h addr=%h cyc=%0d expected be=1100 wd=cafecafe addr=0 cyc=2", sb, sw, sa, rc);
        end
        run_access(1'b1, 2'b10, 1'b0, 32'h20, 32'h89ABCDEF, 32'h0, 1, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (sb !== 4'b1111 || sw !== 32'h89ABCDEF || sa !== 32'h20 || rc !== 3 || ns !== 2 || st !== 1'b1) begin
            n_fail++; $display("FAIL b2b_store_word: got be=%b wd=%h addr=%h cyc=%0d n=%0d expected be=1111 wd=89abcdef addr=20 cyc=3 n=2", sb, sw, sa, rc, ns);
        end
    endtask

    task automatic test_reset_in_lat();
        int seen;
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        req_valid = 1'b1; waitrequest = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (read !== 1'b1) begin
            n_fail++; $display("FAIL rst_lat_strobe: got read=%b expected 1", read);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (read !== 1'b0 || resp_valid !== 1'b0 || address !== 32'h0 || byteenable !== 4'b0) begin
            n_fail++; $display("FAIL rst_lat_clear: got read=%b valid=%b addr=%h be=%b expected 0", read, resp_valid, address, byteenable);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_lat_abandon: got pulses=%0d ready=%b expected pulses=0 ready=1", seen, req_ready);
        end
        run_access(1'b1, 2'b10, 1'b0, 32'h24, 32'h11223344, 32'h0, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
        n_cmp++;
        if (rc !== 2 || sa !== 32'h24 || sw !== 32'h11223344 || swr !== 1'b1) begin
            n_fail++; $display("FAIL rst_lat_after: got cyc=%0d addr=%h wd=%h wr=%b expected cyc=2 addr=24 wd=11223344 wr=1", rc, sa, sw, swr);
        end
    endtask

    task automatic test_misalign();
        int rc, ns; logic [31:0] rd, sa, sw; logic er, sr, swr, st; logic [3:0] sb;
        run_access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h55AA55AA, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
`ifdef MISALIGN_TRAP_EN
        n_cmp++;
        if (ns !== 0 || rc !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL misalign_word_trap: got n=%0d cyc=%0d err=%b rd=%h expected n=0 cyc=1 err=1 rd=0", ns, rc, er, rd);
        end
`else
        n_cmp++;
        if (sr !== 1'b1 || sa !== 32'h0 || sb !== 4'b1111 || er !== 1'b0 || rd !== 32'h55AA55AA || rc !== 2 + RL) begin
            n_fail++; $display("FAIL misalign_word_align: got rd=%b addr=%h be=%b err=%b data=%h cyc=%0d expected rd=1 addr=0 be=1111 err=0 data=55aa55aa", sr, sa, sb, er, rd, rc);
        end
`endif
        run_access(1'b0, 2'b01, 1'b1, 32'h1, 32'h0, 32'h1234ABCD, 0, rc, rd, er, ns, sa, sb, sw, sr, swr, st);
`ifdef MISALIGN_TRAP_EN
        n_cmp++;
        if (ns !== 0 || rc !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL misalign_half_trap: got n=%0d cyc=%0d err=%b rd=%h expected n=0 cyc=1 err=1 rd=0", ns, rc, er, rd);
        end
`else
        n_cmp++;
        if (sb !== 4'b0011 || sa !== 32'h0 || er !== 1'b0 || rd !== 32'h0000ABCD) begin
            n_fail++; $display("FAIL misalign_half_align: got be=%b addr=%h err=%b data=%h expected be=0011 addr=0 err=0 data=0000abcd", sb, sa, er, rd);
        end
`endif
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; waitrequest = 1'b0; readdata = 32'hDEADBEEF;
        test_reset();
        test_store_byte();
        test_load_half();
        test_wait_stall();
        test_load_byte_lat();
        test_back_to_back();
        test_reset_in_lat();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
